axi_dma_controller_axi_slave_mem: RTL

AXI_DMA_CONTROLLER_AXI_SLAVE_MEM -- requirements
Module: axi_dma_controller_axi_slave_mem

---
 rtl/axi_dma_controller_axi_slave_mem.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/axi_dma_controller_axi_slave_mem.sv
// AXI4 slave memory model for the DMA controller subsystem.
// Independent read and write engines, one outstanding burst each, INCR and
// FIXED bursts, byte strobes, SLVERR on unsupported or out-of-range bursts.
module axi_dma_controller_axi_slave_mem #(
    parameter int ADDR_WD   = 32,
    parameter int DATA_WD   = 32,
    parameter int MEM_WORDS = 1024
) (
    input  logic                   clk,
    input  logic                   rst,
    // read address channel
    input  logic                   arvalid,
    input  logic [ADDR_WD-1:0]     araddr,
    input  logic [7:0]             arlen,
    input  logic [2:0]             arsize,
    input  logic [1:0]             arburst,
    output logic                   arready,
    // read data channel
    output logic                   rvalid,
    output logic [DATA_WD-1:0]     rdata,
    output logic [1:0]             rresp,
    output logic                   rlast,
    input  logic                   rready,
    // write address channel
    input  logic                   awvalid,
    input  logic [ADDR_WD-1:0]     awaddr,
    input  logic [7:0]             awlen,
    input  logic [2:0]             awsize,
    input  logic [1:0]             awburst,
    output logic                   awready,
    // write data channel
    input  logic                   wvalid,
    input  logic [DATA_WD-1:0]     wdata,
    input  logic [DATA_WD/8-1:0]   wstrb,
    input  logic                   wlast,
    output logic                   wready,
    // write response channel
    output logic                   bvalid,
    output logic [1:0]             bresp,
    input  logic                   bready
);

    localparam int STRB_WD = DATA_WD / 8;
    localparam int SZ      = $clog2(STRB_WD);
    localparam int IDX_WD  = $clog2(MEM_WORDS);

    // Byte size of the memory, kept 64 bits wide so the range test never
    // overflows the address width.
    localparam longint unsigned MEM_BYTES = longint'(MEM_WORDS) * longint'(STRB_WD);

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic       {R_IDLE, R_DATA}         r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

    // A burst is rejected when its type is WRAP/reserved, its beat size is
    // not the full bus width, or its start address lies beyond the memory.
    function automatic logic burst_err(input logic [ADDR_WD-1:0] addr,
                                       input logic [2:0]         size,
                                       input logic [1:0]         burst);
        return (burst != BURST_FIXED && burst != BURST_INCR) ||
               (size != 3'(SZ)) ||
               (64'(addr) >= MEM_BYTES);
    endfunction

    logic [DATA_WD-1:0] mem [MEM_WORDS];

    // read engine state
    r_state_t            r_state;
    logic [IDX_WD-1:0]   r_idx;     // word index of the next beat to fetch
    logic                r_fixed;
    logic                r_err;
    logic [7:0]          r_len;
    logic [7:0]          r_cnt;     // index of the beat currently on rdata

    // write engine state
    w_state_t            w_state;
    logic [IDX_WD-1:0]   w_idx;     // word index of the beat being accepted
    logic                w_fixed;
    logic                w_err;
    logic                w_len_bad; // wlast was missing on the awlen beat
    logic [7:0]          w_len;
    logic [7:0]          w_cnt;

    logic [IDX_WD-1:0]   ar_idx;
    logic [IDX_WD-1:0]   aw_idx;
    logic                ar_err;
    logic                aw_err;

    assign ar_idx = araddr[SZ +: IDX_WD];
    assign aw_idx = awaddr[SZ +: IDX_WD];
    assign ar_err = burst_err(araddr, arsize, arburst);
    assign aw_err = burst_err(awaddr, awsize, awburst);

    // Read FSM: accept AR in idle, then stream beats from a prefetched register
    // that reloads on entry and after every R handshake (no bubbles).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values, whatever the statement order.
            r_state <= R_IDLE;
            arready <= 1'b1;
            rvalid  <= 1'b0;
            rdata   <= '0;
            rresp   <= RESP_OKAY;
            rlast   <= 1'b0;
            r_idx   <= '0;
            r_fixed <= 1'b0;
            r_err   <= 1'b0;
            r_len   <= '0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (arvalid) begin
                        r_state <= R_DATA;
                        arready <= 1'b0;
                        rvalid  <= 1'b1;
                        r_err   <= ar_err;
                        r_fixed <= (arburst == BURST_FIXED);
                        r_len   <= arlen;
                        r_cnt   <= '0;
                        rlast   <= (arlen == 8'd0);
                        rresp   <= ar_err ? RESP_SLVERR : RESP_OKAY;
                        rdata   <= ar_err ? '0 : mem[ar_idx];
                        r_idx   <= (arburst == BURST_FIXED) ? ar_idx : ar_idx + 1'b1;
                    end
                end
                R_DATA: begin
                    if (rready) begin
                        if (rlast) begin
                            r_state <= R_IDLE;
                            arready <= 1'b1;
                            rvalid  <= 1'b0;
                            rlast   <= 1'b0;
                        end else begin
                            r_cnt <= r_cnt + 8'd1;
                            rlast <= (r_cnt + 8'd1 == r_len);
                            rdata <= r_err ? '0 : mem[r_idx];
                            if (!r_fixed) begin
                                r_idx <= r_idx + 1'b1;
                            end
                        end
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    // Write FSM: accept AW, take data beats until wlast, then hold the response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_state   <= W_IDLE;
            awready   <= 1'b1;
            wready    <= 1'b0;
            bvalid    <= 1'b0;
            bresp     <= RESP_OKAY;
            w_idx     <= '0;
            w_fixed   <= 1'b0;
            w_err     <= 1'b0;
            w_len_bad <= 1'b0;
            w_len     <= '0;
            w_cnt     <= '0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (awvalid) begin
                        w_state   <= W_DATA;
                        awready   <= 1'b0;
                        wready    <= 1'b1;
                        w_idx     <= aw_idx;
                        w_fixed   <= (awburst == BURST_FIXED);
                        w_err     <= aw_err;
                        w_len_bad <= 1'b0;
                        w_len     <= awlen;
                        w_cnt     <= '0;
                    end
                end
                W_DATA: begin
                    if (wvalid) begin
                        w_cnt <= w_cnt + 8'd1;
                        if (!w_fixed) begin
                            w_idx <= w_idx + 1'b1;
                        end
                        if (wlast) begin
                            // an early wlast shows up as a count short of awlen
                            w_state <= W_RESP;
                            wready  <= 1'b0;
                            bvalid  <= 1'b1;
                            bresp   <= (w_err || w_len_bad || (w_cnt != w_len)) ?
                                       RESP_SLVERR : RESP_OKAY;
                        end else if (w_cnt == w_len) begin
                            // late wlast: remembered until the burst finally ends
                            w_len_bad <= 1'b1;
                        end
                    end
                end
                W_RESP: begin
                    if (bready) begin
                        w_state <= W_IDLE;
                        bvalid  <= 1'b0;
                        awready <= 1'b1;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    // Byte-strobed memory update for every accepted beat of a valid burst.
    always_ff @(posedge clk) begin
        // NOTE: the storage array has no reset; contents survive rst, and the
        // write enable is gated by wready, which rst clears asynchronously.
        if (wready && wvalid && !w_err) begin
            for (int b = 0; b < STRB_WD; b++) begin
                if (wstrb[b]) begin
                    mem[w_idx][b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
        end
    end

endmodule
